sched_ws: RTL and testbench

- Parametrised multi-cycle phase scheduler for the CPU core; successor to the fixed four-phase scheduler (fetch/exec/mem/writeback).
- Generalised to NPH phases.
- Adds memory wait states (programmed count plus bus ready handshake), per-instruction phase skipping, and run/idle control.
- Sits between the clock/reset and the CPU datapath. The datapath uses ph[k] & ph_adv as register enables.

---
 rtl/sched_ws_pkg.sv | 16 +
 rtl/sched_next_ph.sv | 30 +++
 rtl/sched_ws.sv | 180 ++++++++++++++++++
 tb/tb_sched_ws.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_ws_pkg.sv
// Shared scheduler definitions for sched_ws, its sub-module, the CPU top and
// the bench: FSM state encodings and the bit layout of clk_stat.
package sched_ws_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // clk_stat = {ph_adv, stall, active}
    localparam int CS_ACT   = 0;
    localparam int CS_STALL = 1;
    localparam int CS_ADV   = 2;
    localparam int CS_W     = 3;

endpackage

// File: rtl/sched_next_ph.sv
// Next-phase priority finder: picks the lowest phase index above pidx whose
// skip bit is clear. When none remains the instruction is complete and the
// sequence wraps to phase 0 (fetch), which can never be skipped.
module sched_next_ph #(
    parameter int NPH = 4,
    parameter int PIW = 3
) (
    input  logic [PIW-1:0] pidx,
    input  logic [NPH-1:0] skip_mask,
    output logic [PIW-1:0] nxt_idx,
    output logic           wrap
);

    // Bit 0 of skip_mask has no meaning: fetch is always executed.
    logic unused_skip0;
    assign unused_skip0 = skip_mask[0];

    // Scan from the top down so the lowest eligible phase wins.
    always_comb begin
        nxt_idx = '0;
        wrap    = 1'b1;
        for (int j = NPH - 1; j >= 1; j--) begin
            if ((PIW'(j) > pidx) && !skip_mask[j]) begin
                nxt_idx = PIW'(j);
                wrap    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sched_ws.sv
// Multi-cycle phase scheduler with memory wait states, per-instruction phase
// skipping and run/idle control. The datapath uses ph[k] & ph_adv as register
// enables. Optional performance counters are built when SCHED_PERF_EN is
// defined; otherwise perf_inst/perf_stall read as zero and perf_clr is unused.
module sched_ws
    import sched_ws_pkg::*;
#(
    parameter int NPH = 4,
    parameter int WSW = 4,
    parameter int PIW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_rdy,
    input  logic [WSW-1:0]   ws_cfg,
    input  logic [NPH-1:0]   mem_ph_mask,
    input  logic [NPH-1:0]   skip_mask,
    output logic [NPH-1:0]   ph,
    output logic [PIW-1:0]   ph_idx,
    output logic             ph_adv,
    output logic             stall,
    output logic [CS_W-1:0]  clk_stat,
    input  logic             perf_clr,
    output logic [31:0]      perf_inst,
    output logic [31:0]      perf_stall
);

    // Wait-state count loaded when a phase is entered: memory phases get the
    // programmed count, all others start with no wait.
    function automatic logic [WSW-1:0] entry_wcnt(input logic [PIW-1:0] idx,
                                                  input logic [NPH-1:0] mask,
                                                  input logic [WSW-1:0] ws);
        logic [WSW-1:0] w;
        w = '0;
        for (int k = 0; k < NPH; k++) begin
            if (idx == PIW'(k) && mask[k]) begin
                w = ws;
            end
        end
        return w;
    endfunction

    state_t         state_q, state_d;
    logic [PIW-1:0] pidx_q, pidx_d;
    logic [WSW-1:0] wcnt_q, wcnt_d;

    logic           active;
    logic           cur_mem;
    logic [NPH-1:0] ph_dec;
    logic           adv;
    logic [PIW-1:0] nxt_idx;
    logic           wrap;

    sched_next_ph #(
        .NPH (NPH),
        .PIW (PIW)
    ) u_next_ph (
        .pidx      (pidx_q),
        .skip_mask (skip_mask),
        .nxt_idx   (nxt_idx),
        .wrap      (wrap)
    );

    // Decode the current phase index into a one-hot vector and pick up its
    // memory-phase flag (read live, so mask changes gate mem_rdy at once).
    always_comb begin
        cur_mem = 1'b0;
        ph_dec  = '0;
        for (int k = 0; k < NPH; k++) begin
            if (pidx_q == PIW'(k)) begin
                cur_mem   = mem_ph_mask[k];
                ph_dec[k] = 1'b1;
            end
        end
    end

    assign active = (state_q == ST_ACTIVE);
    // A phase ends once its wait count has run out and, for a memory phase,
    // the bus reports ready in the same cycle.
    assign adv    = active && (wcnt_q == '0) && (!cur_mem || mem_rdy);

    // State, phase index and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pidx_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pidx_q  <= pidx_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic: start on run, step phases on adv, and look at run
    // only at the instruction boundary so a started instruction always ends.
    always_comb begin
        state_d = state_q;
        pidx_d  = pidx_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_ACTIVE;
                    pidx_d  = '0;
                    wcnt_d  = entry_wcnt('0, mem_ph_mask, ws_cfg);
                end
            end
            ST_ACTIVE: begin
                if (adv) begin
                    if (wrap) begin
                        pidx_d = '0;
                        if (run) begin
                            wcnt_d = entry_wcnt('0, mem_ph_mask, ws_cfg);
                        end else begin
                            state_d = ST_IDLE;
                            wcnt_d  = '0;
                        end
                    end else begin
                        pidx_d = nxt_idx;
                        wcnt_d = entry_wcnt(nxt_idx, mem_ph_mask, ws_cfg);
                    end
                end else if (wcnt_q != '0) begin
                    // Wait states count down regardless of mem_rdy.
                    wcnt_d = wcnt_q - WSW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pidx_d  = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    // Phase outputs and status; everything reads zero while idle.
    always_comb begin
        ph                 = active ? ph_dec : '0;
        ph_idx             = active ? pidx_q : '0;
        ph_adv             = adv;
        stall              = active && !adv;
        clk_stat           = '0;
        clk_stat[CS_ACT]   = active;
        clk_stat[CS_STALL] = active && !adv;
        clk_stat[CS_ADV]   = adv;
    end

`ifdef SCHED_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_stall_q;

    // Instruction and stall counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else if (perf_clr) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (adv && wrap) begin
                perf_inst_q <= perf_inst_q + 32'd1;
            end
            if (active && !adv) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_inst  = perf_inst_q;
    assign perf_stall = perf_stall_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_inst       = '0;
    assign perf_stall      = '0;
`endif

endmodule

// File: tb/tb_sched_ws.sv
// Self-checking bench for sched_ws (NPH=4). Each scenario task pushes
// per-cycle stimulus together with the expected {ph, ph_adv, stall, clk_stat}
// into a scoreboard queue, then pops entries cycle by cycle, drives the
// stimulus and compares the DUT outputs. Perf expectations follow
// SCHED_PERF_EN.
module tb_sched_ws;
    import sched_ws_pkg::*;

    localparam int NPH = 4;
    localparam int WSW = 4;
    localparam int PIW = 3;

    logic            clk;
    logic            reset;
    logic            run;
    logic            mem_rdy;
    logic [WSW-1:0]  ws_cfg;
    logic [NPH-1:0]  mem_ph_mask;
    logic [NPH-1:0]  skip_mask;
    logic [NPH-1:0]  ph;
    logic [PIW-1:0]  ph_idx;
    logic            ph_adv;
    logic            stall;
    logic [CS_W-1:0] clk_stat;
    logic            perf_clr;
    logic [31:0]     perf_inst;
    logic [31:0]     perf_stall;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       run;
        logic       rdy;
        logic [3:0] skip;
        logic [8:0] exp;   // {ph, ph_adv, stall, clk_stat}
    } cyc_t;

    cyc_t sb[$];

    sched_ws #(
        .NPH (NPH),
        .WSW (WSW),
        .PIW (PIW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mem_rdy     (mem_rdy),
        .ws_cfg      (ws_cfg),
        .mem_ph_mask (mem_ph_mask),
        .skip_mask   (skip_mask),
        .ph          (ph),
        .ph_idx      (ph_idx),
        .ph_adv      (ph_adv),
        .stall       (stall),
        .clk_stat    (clk_stat),
        .perf_clr    (perf_clr),
        .perf_inst   (perf_inst),
        .perf_stall  (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic cyc_t mk(input logic r, input logic rdy, input logic [3:0] sk,
                                input logic [3:0] p, input logic a, input logic s);
        cyc_t c;
        logic [2:0] cs;
        cs           = '0;
        cs[CS_ADV]   = a;
        cs[CS_STALL] = s;
        cs[CS_ACT]   = |p;
        c.run  = r;
        c.rdy  = rdy;
        c.skip = sk;
        c.exp  = {p, a, s, cs};
        return c;
    endfunction

    // Drive one cycle's inputs after the falling edge and sample outputs 1ns later.
    task automatic run_cycle(input cyc_t c, output logic [8:0] obs);
        @(negedge clk);
        run       = c.run;
        mem_rdy   = c.rdy;
        skip_mask = c.skip;
        #1;
        obs = {ph, ph_adv, stall, clk_stat};
    endtask

    // Hold reset for two cycles, then release with the given run level.
    task automatic do_reset(input logic r);
        reset     = 1'b0;
        run       = 1'b0;
        mem_rdy   = 1'b0;
        skip_mask = '0;
        perf_clr  = 1'b0;
        repeat (2) @(negedge clk);
        run   = r;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_chk++;
        if ({ph, ph_idx, ph_adv, stall, clk_stat} !== 12'd0) begin
            $display("FAIL reset_outputs: got %b want 0", {ph, ph_idx, ph_adv, stall, clk_stat});
        end else n_pass++;
        n_chk++;
        if ({perf_inst, perf_stall} !== 64'd0) begin
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_inst, perf_stall);
        end else n_pass++;
    endtask

    task automatic test_basic();
        cyc_t c;
        logic [8:0] obs;
        ws_cfg = '0; mem_ph_mask = '0;
        do_reset(1'b1);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(1, 0, 4'b0000, 4'b0001, 1, 0));
            sb.push_back(mk(1, 0, 4'b0000, 4'b0010, 1, 0));
            sb.push_back(mk(1, 0, 4'b0000, 4'b0100, 1, 0));
            sb.push_back(mk(1, 0, 4'b0000, 4'b1000, 1, 0));
        end
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL basic[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        cyc_t c;
        logic [8:0] obs;
        logic [31:0] e_inst, e_stall;
        ws_cfg = 4'd2; mem_ph_mask = 4'b0101;
        do_reset(1'b0);
        sb.push_back(mk(1, 1, 0, 4'b0000, 0, 0));
        sb.push_back(mk(1, 1, 0, 4'b0001, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0001, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0001, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b0010, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b0100, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0100, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0100, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b1000, 1, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL wait_states[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
        end
`ifdef SCHED_PERF_EN
        e_inst = 32'd1; e_stall = 32'd4;
`else
        e_inst = 32'd0; e_stall = 32'd0;
`endif
        @(posedge clk);
        #1;
        n_chk++;
        if (perf_inst !== e_inst || perf_stall !== e_stall)
            $display("FAIL ws_perf: got inst=%0d stall=%0d want inst=%0d stall=%0d",
                     perf_inst, perf_stall, e_inst, e_stall);
        else n_pass++;
    endtask

    task automatic test_mem_rdy();
        cyc_t c;
        logic [8:0] obs;
        ws_cfg = 4'd0; mem_ph_mask = 4'b0100;
        do_reset(1'b0);
        sb.push_back(mk(1, 0, 0, 4'b0000, 0, 0));
        sb.push_back(mk(1, 0, 0, 4'b0001, 1, 0));
        sb.push_back(mk(1, 0, 0, 4'b0010, 1, 0));
        for (int i = 0; i < 5; i++) sb.push_back(mk(1, 0, 0, 4'b0100, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0100, 1, 0));
        sb.push_back(mk(1, 0, 0, 4'b1000, 1, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL mem_rdy[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if (clk_stat !== 3'b011 || ph_idx !== 3'd2)
                    $display("FAIL mem_rdy_stat: got cs=%b idx=%0d want cs=011 idx=2", clk_stat, ph_idx);
                else n_pass++;
            end
        end
    endtask

    task automatic test_skip();
        cyc_t c;
        logic [8:0] obs;
        logic [31:0] e_inst;
        ws_cfg = 4'd0; mem_ph_mask = 4'b0000;
        do_reset(1'b0);
        sb.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0));
        sb.push_back(mk(1, 0, 4'b1010, 4'b0001, 1, 0));
        sb.push_back(mk(1, 0, 4'b1010, 4'b0100, 1, 0));
        sb.push_back(mk(1, 0, 4'b1110, 4'b0001, 1, 0));
        sb.push_back(mk(1, 0, 4'b1110, 4'b0001, 1, 0));
        sb.push_back(mk(1, 0, 4'b1110, 4'b0001, 1, 0));
        sb.push_back(mk(1, 0, 4'b0000, 4'b0001, 1, 0));
        sb.push_back(mk(1, 0, 4'b0000, 4'b0010, 1, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL skip[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
        end
`ifdef SCHED_PERF_EN
        e_inst = 32'd4;
`else
        e_inst = 32'd0;
`endif
        @(posedge clk);
        #1;
        n_chk++;
        if (perf_inst !== e_inst || perf_stall !== 32'd0)
            $display("FAIL skip_perf: got inst=%0d stall=%0d want inst=%0d stall=0",
                     perf_inst, perf_stall, e_inst);
        else n_pass++;
    endtask

    task automatic test_run_stop();
        cyc_t c;
        logic [8:0] obs;
        ws_cfg = 4'd0; mem_ph_mask = 4'b0000;
        do_reset(1'b0);
        sb.push_back(mk(1, 0, 0, 4'b0000, 0, 0));
        sb.push_back(mk(1, 0, 0, 4'b0001, 1, 0));
        sb.push_back(mk(0, 0, 0, 4'b0010, 1, 0));
        sb.push_back(mk(0, 0, 0, 4'b0100, 1, 0));
        sb.push_back(mk(0, 0, 0, 4'b1000, 1, 0));
        sb.push_back(mk(0, 0, 0, 4'b0000, 0, 0));
        sb.push_back(mk(0, 0, 0, 4'b0000, 0, 0));
        sb.push_back(mk(1, 0, 0, 4'b0000, 0, 0));
        sb.push_back(mk(1, 0, 0, 4'b0001, 1, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL run_stop[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_phase();
        cyc_t c;
        logic [8:0] obs;
        logic [31:0] e_inst, e_stall;
        ws_cfg = 4'd3; mem_ph_mask = 4'b0100;
        do_reset(1'b0);
        sb.push_back(mk(1, 1, 0, 4'b0000, 0, 0));
        sb.push_back(mk(1, 1, 0, 4'b0001, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b0010, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b0100, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0100, 0, 1));
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL rst_pre[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
        end
        // Assert reset between clock edges: outputs must clear at once.
        #2;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({ph, ph_idx, ph_adv, stall, clk_stat, perf_inst, perf_stall} !== 76'd0)
            $display("FAIL rst_async: got ph=%b idx=%0d adv=%b stall=%b cs=%b inst=%0d pstall=%0d want all 0",
                     ph, ph_idx, ph_adv, stall, clk_stat, perf_inst, perf_stall);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        // run stays high: phase 0 at the next edge, phase 2 wait reloaded.
        sb.push_back(mk(1, 1, 0, 4'b0001, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b0010, 1, 0));
        for (int i = 0; i < 3; i++) sb.push_back(mk(1, 1, 0, 4'b0100, 0, 1));
        sb.push_back(mk(1, 1, 0, 4'b0100, 1, 0));
        sb.push_back(mk(1, 1, 0, 4'b1000, 1, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            c = sb.pop_front();
            run_cycle(c, obs);
            n_chk++;
            if (obs !== c.exp) $display("FAIL rst_post[%0d]: got %b want %b", i, obs, c.exp);
            else n_pass++;
        end
`ifdef SCHED_PERF_EN
        e_inst = 32'd1; e_stall = 32'd3;
`else
        e_inst = 32'd0; e_stall = 32'd0;
`endif
        @(posedge clk);
        #1;
        n_chk++;
        if (perf_inst !== e_inst || perf_stall !== e_stall)
            $display("FAIL rst_perf: got inst=%0d stall=%0d want inst=%0d stall=%0d",
                     perf_inst, perf_stall, e_inst, e_stall);
        else n_pass++;
        @(negedge clk);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (perf_inst !== 32'd0 || perf_stall !== 32'd0)
            $display("FAIL perf_clr: got inst=%0d stall=%0d want 0/0", perf_inst, perf_stall);
        else n_pass++;
        @(negedge clk);
        perf_clr = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        run         = 1'b0;
        mem_rdy     = 1'b0;
        ws_cfg      = '0;
        mem_ph_mask = '0;
        skip_mask   = '0;
        perf_clr    = 1'b0;
        test_reset();
        test_basic();
        test_wait_states();
        test_mem_rdy();
        test_skip();
        test_run_stop();
        test_reset_mid_phase();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
